// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: widths, AXI constants,
// FSM state encoding and the request record latched when leaving IDLE.
package cache_miss_ctrl_pkg;

  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned STRB_W         = DATA_W / 8;
  localparam int unsigned ID_W           = 4;
  localparam int unsigned LEN_W          = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_AW,
    ST_WB_W,
    ST_WB_B,
    ST_RD_AR,
    ST_RD_R,
    ST_COMMIT,
    ST_DONE
  } state_e;

  // Transaction context captured on leaving IDLE.
  typedef struct packed {
    logic              cached;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [STRB_W-1:0] wen;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cache_miss_ctrl_beat_cnt.sv
// Burst beat counter: clear, saturating increment, and last-beat compare
// against the current burst length.
//   clr/inc  : clear to 0 / advance one beat (clr wins)
//   len      : AXI burst length of the running transaction
//   beat     : current beat index
//   is_last  : beat == len
module cache_miss_ctrl_beat_cnt
  import cache_miss_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              inc,
  input  logic [LEN_W-1:0]  len,
  output logic [BEAT_W-1:0] beat,
  output logic              is_last
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(LINE_WORDS - 1);

  logic [BEAT_W-1:0] beat_d, beat_q;

  // Saturate at the last word so the index never leaves the line.
  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (inc && (beat_q != BEAT_MAX)) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) beat_q <= '0;
    else         beat_q <= beat_d;
  end

  assign beat    = beat_q;
  assign is_last = (LEN_W'(beat_q) == len);

endmodule

// File: rtl/cache_miss_ctrl.sv
// Line replacement sequencer for a direct-mapped 32-byte-line cache.
// On a miss: optional victim write-back burst, refill burst, then a tag
// refresh pulse. Also performs single-beat uncached loads and stores.
// Ports:
//   miss/write_back/axi_waddr/axi_raddr : cached miss request from tag store
//   unc_*                                : uncached request / completion
//   victim_idx/victim_word               : combinational data-store read
//   refill_we/refill_idx/refill_data     : data-store refill write
//   refresh                              : tag-store update pulse
//   busy                                 : controller not idle
//   ar*/r*/aw*/w*/b*                     : AXI master subset
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter  int unsigned AXI_ID     = 0,
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              miss,
  input  logic              write_back,
  input  logic [ADDR_W-1:0] axi_raddr,
  input  logic [ADDR_W-1:0] axi_waddr,
  input  logic              unc_req,
  input  logic [STRB_W-1:0] unc_wen,
  input  logic [DATA_W-1:0] unc_wdata,
  output logic [DATA_W-1:0] unc_rdata,
  output logic              unc_done,
  output logic              refresh,
  output logic [BEAT_W-1:0] victim_idx,
  input  logic [DATA_W-1:0] victim_word,
  output logic              refill_we,
  output logic [BEAT_W-1:0] refill_idx,
  output logic [DATA_W-1:0] refill_data,
  output logic              busy,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  state_e            state_d, state_q;
  req_t              req_d, req_q;
  logic [DATA_W-1:0] unc_rdata_d, unc_rdata_q;
  logic              beat_clr, beat_inc, beat_last;
  logic [BEAT_W-1:0] beat;
  logic [LEN_W-1:0]  burst_len;

  assign burst_len = req_q.cached ? LEN_W'(LINE_WORDS - 1) : '0;

  cache_miss_ctrl_beat_cnt #(.LINE_WORDS(LINE_WORDS)) u_beat_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (beat_clr),
    .inc     (beat_inc),
    .len     (burst_len),
    .beat    (beat),
    .is_last (beat_last)
  );

  // Next-state, request latch and beat control.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    unc_rdata_d = unc_rdata_q;
    beat_clr    = 1'b0;
    beat_inc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A cached miss outranks a pending uncached access.
        if (miss) begin
          req_d.cached = 1'b1;
          req_d.waddr  = axi_waddr;
          req_d.raddr  = axi_raddr;
          req_d.wen    = '0;
          req_d.wdata  = '0;
          state_d      = write_back ? ST_WB_AW : ST_RD_AR;
        end else if (unc_req) begin
          req_d.cached = 1'b0;
          req_d.waddr  = axi_raddr;
          req_d.raddr  = axi_raddr;
          req_d.wen    = unc_wen;
          req_d.wdata  = unc_wdata;
          state_d      = (|unc_wen) ? ST_WB_AW : ST_RD_AR;
        end
      end
      ST_WB_AW: begin
        if (awready) begin
          beat_clr = 1'b1;
          state_d  = ST_WB_W;
        end
      end
      ST_WB_W: begin
        if (wready) begin
          beat_inc = 1'b1;
          if (beat_last) state_d = ST_WB_B;
        end
      end
      ST_WB_B: begin
        if (bvalid) state_d = req_q.cached ? ST_RD_AR : ST_DONE;
      end
      ST_RD_AR: begin
        if (arready) begin
          beat_clr = 1'b1;
          state_d  = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (rvalid) begin
          if (req_q.cached) beat_inc    = 1'b1;
          else              unc_rdata_d = rdata;
          // rlast, not the beat count, terminates the burst.
          if (rlast) state_d = req_q.cached ? ST_COMMIT : ST_DONE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      unc_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      unc_rdata_q <= unc_rdata_d;
    end
  end

  // Channel controls decode from the state register; payloads come from latched request.
  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = req_q.waddr;
  assign awlen   = burst_len;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign awvalid = (state_q == ST_WB_AW);

  assign victim_idx = beat;
  assign wdata      = req_q.cached ? victim_word : req_q.wdata;
  assign wstrb      = req_q.cached ? {STRB_W{1'b1}} : req_q.wen;
  assign wvalid     = (state_q == ST_WB_W);
  assign wlast      = wvalid & beat_last;
  assign bready     = (state_q == ST_WB_B);

  assign arid    = ID_W'(AXI_ID);
  assign araddr  = req_q.raddr;
  assign arlen   = burst_len;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arvalid = (state_q == ST_RD_AR);
  assign rready  = (state_q == ST_RD_R);

  assign refill_we   = rready & rvalid & req_q.cached;
  assign refill_idx  = beat;
  assign refill_data = rdata;

  assign refresh   = (state_q == ST_COMMIT);
  assign unc_done  = (state_q == ST_DONE);
  assign unc_rdata = unc_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed/randomized bench for cache_miss_ctrl with an inline AXI slave and
// line-level expectations (victim words, refill words, pulse timing).
module tb_cache_miss_ctrl;
  import cache_miss_ctrl_pkg::*;

  localparam int NW    = 8;
  localparam int BOUND = 200;

  logic        clk = 1'b0;
  logic        resetn;
  logic        miss, write_back, unc_req;
  logic [31:0] axi_raddr, axi_waddr, unc_wdata, unc_rdata;
  logic [3:0]  unc_wen;
  logic        unc_done, refresh, refill_we, busy;
  logic [2:0]  victim_idx, refill_idx;
  logic [31:0] victim_word, refill_data;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  logic [31:0] vline [NW];
  logic [31:0] rline [NW];
  logic [31:0] wexp  [NW];
  logic [31:0] exp_unc_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign victim_word = vline[victim_idx];

  cache_miss_ctrl dut (
    .clk(clk), .resetn(resetn), .miss(miss), .write_back(write_back),
    .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .unc_req(unc_req),
    .unc_wen(unc_wen), .unc_wdata(unc_wdata), .unc_rdata(unc_rdata),
    .unc_done(unc_done), .refresh(refresh), .victim_idx(victim_idx),
    .victim_word(victim_word), .refill_we(refill_we), .refill_idx(refill_idx),
    .refill_data(refill_data), .busy(busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rdata   = $urandom;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_refill_we"}, refill_we, 0);
    chk({tag, "_refresh"}, refresh, 0);
    chk({tag, "_unc_done"}, unc_done, 0);
    chk({tag, "_unc_rdata"}, unc_rdata, exp_unc_rdata);
  endtask

  task automatic launch(input logic m, input logic wb, input logic ur,
                        input logic [31:0] wa, input logic [31:0] ra,
                        input logic [3:0] wen, input logic [31:0] wd);
    @(negedge clk);
    slave_idle();
    miss = m; write_back = wb; unc_req = ur;
    axi_waddr = wa; axi_raddr = ra; unc_wen = wen; unc_wdata = wd;
    #1;
    chk("launch_idle", busy, 0);
  endtask

  task automatic aw_phase(input logic [31:0] ea, input logic [7:0] elen, input int delay);
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      slave_idle();
      axi_waddr = $urandom; axi_raddr = $urandom;
      awready = (c >= delay);
      #1;
      chk("aw_valid", awvalid, 1);
      chk("aw_addr", awaddr, ea);
      chk("aw_len", awlen, elen);
      chk("aw_size", awsize, 3'd2);
      chk("aw_burst", awburst, 2'b01);
      chk("aw_id", awid, 0);
      chk("aw_no_ar", arvalid, 0);
    end
  endtask

  task automatic w_phase(input int n, input logic [3:0] estrb, input logic stall);
    int k = 0;
    for (int c = 0; c < BOUND && k < n; c++) begin
      @(negedge clk);
      slave_idle();
      wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("w_valid", wvalid, 1);
      if (wready) begin
        chk("w_data", wdata, wexp[k]);
        chk("w_strb", wstrb, estrb);
        chk("w_last", wlast, (k == n - 1));
        k++;
      end
    end
    chk("w_beats", k, n);
  endtask

  task automatic b_phase(input int delay);
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      slave_idle();
      bvalid = (c >= delay);
      #1;
      chk("b_ready", bready, 1);
      chk("b_no_ar", arvalid, 0);
    end
  endtask

  task automatic ar_phase(input logic [31:0] ea, input logic [7:0] elen, input int delay);
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      slave_idle();
      axi_waddr = $urandom; axi_raddr = $urandom;
      arready = (c >= delay);
      #1;
      chk("ar_valid", arvalid, 1);
      chk("ar_addr", araddr, ea);
      chk("ar_len", arlen, elen);
      chk("ar_size", arsize, 3'd2);
      chk("ar_burst", arburst, 2'b01);
      chk("ar_id", arid, 0);
      chk("ar_no_aw", awvalid, 0);
    end
  endtask

  task automatic r_phase(input int n, input logic cached, input logic stall, input int stop_at);
    int k = 0;
    for (int c = 0; c < BOUND && k < stop_at; c++) begin
      @(negedge clk);
      slave_idle();
      rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid) begin
        rdata = rline[k];
        rlast = (k == n - 1);
      end
      #1;
      chk("r_ready", rready, 1);
      chk("r_we", refill_we, cached & rvalid);
      chk("r_no_refresh", refresh, 0);
      if (cached && rvalid) begin
        chk("r_idx", refill_idx, k);
        chk("r_data", refill_data, rline[k]);
      end
      if (rvalid) k++;
    end
    chk("r_beats", k, stop_at);
  endtask

  task automatic finish_cached();
    @(negedge clk);
    slave_idle();
    #1;
    chk("commit_refresh", refresh, 1);
    chk("commit_busy", busy, 1);
    chk("commit_no_done", unc_done, 0);
    miss = 1'b0; write_back = 1'b0;
    @(negedge clk);
    #1;
    chk("post_commit_refresh", refresh, 0);
    chk("post_commit_busy", busy, 0);
  endtask

  task automatic finish_unc();
    @(negedge clk);
    slave_idle();
    #1;
    chk("done_pulse", unc_done, 1);
    chk("done_no_refresh", refresh, 0);
    chk("done_no_ar", arvalid, 0);
    chk("done_rdata", unc_rdata, exp_unc_rdata);
    unc_req = 1'b0;
    @(negedge clk);
    #1;
    chk("post_done_pulse", unc_done, 0);
    chk("post_done_busy", busy, 0);
  endtask

  // Full cached replacement: optional victim write-back, then refill.
  task automatic cached_miss(input logic wb, input logic [31:0] wa, input logic [31:0] ra,
                             input logic stall);
    for (int i = 0; i < NW; i++) begin
      wexp[i]  = vline[i];
      rline[i] = $urandom;
    end
    launch(1'b1, wb, 1'b0, wa, ra, 4'h0, 32'h0);
    if (wb) begin
      aw_phase(wa, 8'd7, stall ? $urandom_range(0, 4) : 0);
      w_phase(NW, 4'hF, stall);
      b_phase(stall ? $urandom_range(0, 4) : 0);
    end
    ar_phase(ra, 8'd7, stall ? $urandom_range(0, 4) : 0);
    r_phase(NW, 1'b1, stall, NW);
    finish_cached();
  endtask

  logic [31:0] ua, ra;

  initial begin
    resetn = 1'b0;
    miss = 1'b0; write_back = 1'b0; unc_req = 1'b0;
    axi_raddr = '0; axi_waddr = '0; unc_wen = '0; unc_wdata = '0;
    exp_unc_rdata = '0;
    slave_idle();
    for (int i = 0; i < NW; i++) vline[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    resetn = 1'b1;

    // Cached miss, no victim, counting refill words.
    for (int i = 0; i < NW; i++) rline[i] = 32'(i);
    launch(1'b1, 1'b0, 1'b0, 32'h0, 32'h1FC0_0020, 4'h0, 32'h0);
    ar_phase(32'h1FC0_0020, 8'd7, 0);
    r_phase(NW, 1'b1, 1'b0, NW);
    finish_cached();

    // Miss with victim write-back of 0xA0..0xA7.
    for (int i = 0; i < NW; i++) vline[i] = 32'hA0 + 32'(i);
    cached_miss(1'b1, 32'h0000_1000, $urandom & 32'hFFFF_FFE0, 1'b0);

    // Uncached partial store.
    ua = $urandom & 32'hFFFF_FFFC;
    wexp[0] = 32'h1234_5678;
    launch(1'b0, 1'b0, 1'b1, 32'h0, ua, 4'b0011, 32'h1234_5678);
    aw_phase(ua, 8'd0, 1);
    w_phase(1, 4'b0011, 1'b0);
    b_phase(2);
    finish_unc();

    // Uncached load with arready held off for 5 cycles.
    ua = $urandom & 32'hFFFF_FFFC;
    rline[0] = 32'hDEAD_BEEF;
    launch(1'b0, 1'b0, 1'b1, 32'h0, ua, 4'h0, $urandom);
    ar_phase(ua, 8'd0, 5);
    r_phase(1, 1'b0, 1'b0, 1);
    exp_unc_rdata = 32'hDEAD_BEEF;
    finish_unc();

    // Miss and uncached load together: miss first, load follows.
    ra = $urandom & 32'hFFFF_FFE0;
    ua = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < NW; i++) rline[i] = $urandom;
    launch(1'b1, 1'b0, 1'b1, 32'h0, ra, 4'h0, 32'h0);
    ar_phase(ra, 8'd7, 1);
    axi_raddr = ua;
    r_phase(NW, 1'b1, 1'b0, NW);
    finish_cached();
    rline[0] = $urandom;
    ar_phase(ua, 8'd0, 0);
    r_phase(1, 1'b0, 1'b0, 1);
    exp_unc_rdata = rline[0];
    finish_unc();

    // Randomized stalls on every channel.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NW; i++) vline[i] = $urandom;
      cached_miss(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFE0,
                  $urandom & 32'hFFFF_FFE0, 1'b1);
    end

    // Asynchronous reset while the refill sits on beat 3.
    ra = $urandom & 32'hFFFF_FFE0;
    for (int i = 0; i < NW; i++) rline[i] = $urandom;
    launch(1'b1, 1'b0, 1'b0, 32'h0, ra, 4'h0, 32'h0);
    ar_phase(ra, 8'd7, 0);
    r_phase(NW, 1'b1, 1'b0, 3);
    @(negedge clk);
    slave_idle();
    rvalid = 1'b1;
    rdata  = rline[3];
    #1;
    chk("pre_reset_idx", refill_idx, 3);
    chk("pre_reset_we", refill_we, 1);
    resetn = 1'b0;
    miss = 1'b0;
    exp_unc_rdata = '0;
    #1;
    check_quiet("async_reset");
    @(negedge clk);
    slave_idle();
    resetn = 1'b1;
    for (int i = 0; i < NW; i++) vline[i] = $urandom;
    cached_miss(1'b1, $urandom & 32'hFFFF_FFE0, $urandom & 32'hFFFF_FFE0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
